// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl shared types
// pc_src, FSM state and opcode constants
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_JR  = 2'd2,
    PC_J   = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DBL2 = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [5:0] OPC_LDW  = 6'd16;
  localparam logic [5:0] OPC_SDW  = 6'd17;
  localparam logic [5:0] OPC_HALT = 6'd63;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating event counter
// Sync clear has priority over count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] out
);

  // Count up on en, stick at all-ones
  always_ff @(posedge clk) begin
    if (clear)
      out <= '0;
    else if (en && (out != {WIDTH{1'b1}}))
      out <= out + 1'b1;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencing controller
// Redirect, stall, double issue, halt
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [5:0] OP_LDW  = OPC_LDW,
  parameter logic [5:0] OP_SDW  = OPC_SDW,
  parameter logic [5:0] OP_HALT = OPC_HALT,
  parameter int         CNT_W   = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [5:0]       d_opcode,
  input  logic [3:0]       d_rd,
  input  logic             load_use,
  input  logic             jump_req,
  input  logic             jr_req,
  input  logic             branch_req,
  output logic [1:0]       pc_src,
  output logic             add_pc,
  output logic             stall,
  output logic             kill,
  output logic             turn_off,
  output logic             add_rd,
  output logic             add_imm,
  output logic             dbl_err,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] kill_cnt,
  output logic [CNT_W-1:0] dbl_cnt
);

  fetch_state_e state, nstate;
  logic         redir;
  logic [1:0]   redir_src;
  logic         is_dbl;
  logic         stall_en;
  logic         kill_en;
  logic         dbl_en;

  assign redir  = branch_req | jr_req | jump_req;
  assign is_dbl = (d_opcode == OP_LDW) |
                  (d_opcode == OP_SDW);

  // Redirect winner: branch > jr > jump
  always_comb begin
    redir_src = PC_SEQ;
    if (branch_req)
      redir_src = PC_BR;
    else if (jr_req)
      redir_src = PC_JR;
    else if (jump_req)
      redir_src = PC_J;
  end

  // State register
  always_ff @(posedge clk) begin
    if (clear)
      state <= RUN;
    else
      state <= nstate;
  end

  // Next state and Mealy fetch controls
  always_comb begin
    nstate   = state;
    pc_src   = PC_SEQ;
    add_pc   = 1'b1;
    stall    = 1'b0;
    kill     = 1'b0;
    turn_off = 1'b0;
    dbl_err  = 1'b0;
    if (clear) begin
      kill   = 1'b1;
      nstate = RUN;
    end else begin
      unique case (state)
        HALT: begin
          stall    = 1'b1;
          kill     = 1'b1;
          turn_off = 1'b1;
        end
        DBL2: begin
          if (redir) begin
            pc_src = redir_src;
            kill   = 1'b1;
            nstate = RUN;
          end else if (load_use) begin
            stall    = 1'b1;
            turn_off = 1'b1;
          end else begin
            nstate = RUN;
          end
        end
        default: begin
          nstate = RUN;
          if (redir) begin
            pc_src = redir_src;
            kill   = 1'b1;
          end else if (load_use) begin
            stall    = 1'b1;
            turn_off = 1'b1;
          end else if (d_opcode == OP_HALT) begin
            kill   = 1'b1;
            nstate = HALT;
          end else if (is_dbl) begin
            if (d_rd[0]) begin
              dbl_err = 1'b1;
            end else begin
              add_pc   = 1'b0;
              turn_off = 1'b1;
              nstate   = DBL2;
            end
          end
        end
      endcase
    end
  end

  assign add_rd  = (state == DBL2) & ~clear;
  assign add_imm = (state == DBL2) & ~clear;
  assign halted  = (state == HALT) & ~clear;

  assign stall_en = stall & ~halted;
  assign kill_en  = redir & ~clear &
                    (state != HALT);
  assign dbl_en   = (state == DBL2) & ~clear &
                    ~redir & ~load_use;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (clear),
    .en    (stall_en),
    .out   (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_kill_cnt (
    .clk   (clk),
    .clear (clear),
    .en    (kill_en),
    .out   (kill_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_dbl_cnt (
    .clk   (clk),
    .clear (clear),
    .en    (dbl_en),
    .out   (dbl_cnt)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// fetch_ctrl bench: directed plan plus
// random traffic against a rule-level model
module tb_fetch_ctrl;

  localparam int W   = 4;
  localparam int SAT = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         clear;
  logic [5:0]   d_opcode;
  logic [3:0]   d_rd;
  logic         load_use, jump_req, jr_req, branch_req;
  logic [1:0]   pc_src;
  logic         add_pc, stall, kill, turn_off;
  logic         add_rd, add_imm, dbl_err, halted;
  logic [W-1:0] stall_cnt, kill_cnt, dbl_cnt;

  int total  = 0;
  int passed = 0;

  // model: in second half of a double / fetch stopped
  bit m_second;
  bit m_stopped;
  int m_stalls, m_kills, m_dbls;

  always #5 clk = ~clk;

  fetch_ctrl #(.CNT_W(W)) dut (
    .clk        (clk),
    .clear      (clear),
    .d_opcode   (d_opcode),
    .d_rd       (d_rd),
    .load_use   (load_use),
    .jump_req   (jump_req),
    .jr_req     (jr_req),
    .branch_req (branch_req),
    .pc_src     (pc_src),
    .add_pc     (add_pc),
    .stall      (stall),
    .kill       (kill),
    .turn_off   (turn_off),
    .add_rd     (add_rd),
    .add_imm    (add_imm),
    .dbl_err    (dbl_err),
    .halted     (halted),
    .stall_cnt  (stall_cnt),
    .kill_cnt   (kill_cnt),
    .dbl_cnt    (dbl_cnt)
  );

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  function automatic int sat_inc(input int v);
    return (v + 1 > SAT) ? SAT : v + 1;
  endfunction

  task automatic step(input bit c,
                      input int op,
                      input int rd,
                      input bit lu,
                      input bit br,
                      input bit jr,
                      input bit jp);
    int  e_src;
    bit  e_addpc, e_stall, e_kill, e_toff, e_err;
    bit  care_addpc, care_toff;
    bit  n_second, n_stopped, redir, dbl_done;
    @(negedge clk);
    clear      = c;
    d_opcode   = 6'(op);
    d_rd       = 4'(rd);
    load_use   = lu;
    branch_req = br;
    jr_req     = jr;
    jump_req   = jp;
    #1;
    redir   = br | jr | jp;
    e_src   = 0;
    e_addpc = 1;
    e_stall = 0;
    e_kill  = 0;
    e_toff  = 0;
    e_err   = 0;
    care_addpc = 1;
    care_toff  = 1;
    n_second  = 0;
    n_stopped = m_stopped;
    dbl_done  = 0;
    if (c) begin
      e_kill    = 1;
      n_stopped = 0;
    end else if (m_stopped) begin
      e_stall    = 1;
      e_kill     = 1;
      e_toff     = 1;
      care_addpc = 0;
    end else if (redir) begin
      e_src  = br ? 1 : (jr ? 2 : 3);
      e_kill = 1;
    end else if (lu) begin
      e_stall    = 1;
      e_toff     = 1;
      care_addpc = 0;
      care_toff  = !m_second;
      n_second   = m_second;
    end else if (m_second) begin
      dbl_done = 1;
    end else if (op == 63) begin
      e_kill    = 1;
      n_stopped = 1;
    end else if (op == 16 || op == 17) begin
      if (rd % 2 == 1) begin
        e_err = 1;
      end else begin
        e_addpc  = 0;
        e_toff   = 1;
        n_second = 1;
      end
    end
    chk("pc_src", pc_src, e_src);
    if (care_addpc) chk("add_pc", add_pc, e_addpc);
    chk("stall", stall, e_stall);
    chk("kill", kill, e_kill);
    if (care_toff) chk("turn_off", turn_off, e_toff);
    chk("dbl_err", dbl_err, e_err);
    chk("add_rd", add_rd, !c && m_second);
    chk("add_imm", add_imm, !c && m_second);
    chk("halted", halted, !c && m_stopped);
    chk("stall_cnt", stall_cnt, m_stalls);
    chk("kill_cnt", kill_cnt, m_kills);
    chk("dbl_cnt", dbl_cnt, m_dbls);
    @(posedge clk);
    if (c) begin
      m_stalls = 0;
      m_kills  = 0;
      m_dbls   = 0;
    end else begin
      if (e_stall && !m_stopped)
        m_stalls = sat_inc(m_stalls);
      if (redir && !m_stopped)
        m_kills = sat_inc(m_kills);
      if (dbl_done)
        m_dbls = sat_inc(m_dbls);
    end
    m_second  = n_second;
    m_stopped = n_stopped;
  endtask

  initial begin
    int op, rd, r;
    bit lu, br, jr, jp, c;
    clear = 1; d_opcode = 0; d_rd = 0;
    load_use = 0; jump_req = 0;
    jr_req = 0; branch_req = 0;
    @(posedge clk);
    m_second = 0; m_stopped = 0;
    m_stalls = 0; m_kills = 0; m_dbls = 0;
    // reset and sequential fetch
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 5, 0, 0, 0, 0, 0);
    step(0, 7, 0, 0, 0, 0, 0);
    step(0, 5, 0, 0, 0, 0, 0);
    // even-rd double
    step(0, 16, 4, 0, 0, 0, 0);
    step(0, 16, 4, 0, 0, 0, 0);
    step(0, 5, 0, 0, 0, 0, 0);
    // odd-rd double
    step(0, 17, 5, 0, 0, 0, 0);
    step(0, 5, 0, 0, 0, 0, 0);
    // redirect priority
    step(0, 5, 0, 1, 1, 1, 0);
    step(0, 5, 0, 0, 0, 1, 1);
    step(0, 5, 0, 0, 0, 0, 1);
    // load_use while in second half
    step(0, 16, 2, 0, 0, 0, 0);
    step(0, 16, 2, 1, 0, 0, 0);
    step(0, 16, 2, 1, 0, 0, 0);
    step(0, 16, 2, 0, 0, 0, 0);
    step(0, 5, 0, 0, 0, 0, 0);
    // redirect aborts second half
    step(0, 17, 0, 0, 0, 0, 0);
    step(0, 17, 0, 0, 1, 0, 0);
    step(0, 5, 0, 0, 0, 0, 0);
    // halt, ignore requests, then clear
    step(0, 63, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      step(0, 5, 0, i % 2, 1, 0, 0);
    step(1, 5, 0, 0, 0, 0, 0);
    step(0, 5, 0, 0, 0, 0, 0);
    // clear in the middle of a double
    step(0, 16, 0, 0, 0, 0, 0);
    step(1, 16, 0, 0, 0, 0, 0);
    step(0, 5, 0, 0, 0, 0, 0);
    // long stall run to saturate stall_cnt
    for (int i = 0; i < SAT + 3; i++)
      step(0, 5, 0, 1, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 15);
      case (r)
        0, 1, 2: op = 16;
        3, 4:    op = 17;
        5:       op = 63;
        default: op = $urandom_range(0, 62);
      endcase
      rd = $urandom_range(0, 15);
      lu = ($urandom_range(0, 5) == 0);
      br = ($urandom_range(0, 9) == 0);
      jr = ($urandom_range(0, 9) == 0);
      jp = ($urandom_range(0, 9) == 0);
      c  = m_stopped ? ($urandom_range(0, 3) == 0)
                     : ($urandom_range(0, 60) == 0);
      step(c, op, rd, lu, br, jr, jp);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction-fetch stage: `program_counter`, `pc_next`, `IS_MEM` and the IF/ID buffer. Each cycle it selects the next-PC source, and generates stall, kill and buffer-freeze controls. It issues double-word instructions as two back-to-back halves and stops fetch on HALT. It sits beside the IF stage and takes hazard and redirect requests from decode; it replaces ad-hoc `double_CU` sequencing with one FSM and adds saturating performance counters.

## Interface
Parameters:
- OP_LDW, 6'd16, opcode of load-double
- OP_SDW, 6'd17, opcode of store-double
- OP_HALT, 6'd63, opcode that stops fetch
- CNT_W, 16, width of each performance counter

Ports:
- clk  input  1  rising-edge clock
- clear  input  1  synchronous, active-high reset
- d_opcode  input  6  opcode of the instruction currently read from instruction memory
- d_rd  input  4  rd field of the same instruction
- load_use  input  1  decode hazard unit requests a one-cycle bubble
- jump_req  input  1  decode resolved a direct jump
- jr_req  input  1  decode resolved a jump-register
- branch_req  input  1  decode resolved a taken branch
- pc_src  output  2  next-PC select: 0 sequential, 1 branch, 2 jr, 3 jump
- add_pc  output  1  1 = PC+1, 0 = hold current PC
- stall  output  1  freeze the PC register
- kill  output  1  replace the fetched instruction with 32'b0
- turn_off  output  1  freeze the pc_buff register
- add_rd  output  1  second half of a double: use rd+1
- add_imm  output  1  second half of a double: use imm+1
- dbl_err  output  1  one-cycle pulse: double issued with odd rd
- halted  output  1  fetch stopped
- stall_cnt, kill_cnt, dbl_cnt  output  CNT_W  saturating event counters

## Operation
- FSM states are RUN, DBL2 and HALT. Reset state is RUN.
- Per-cycle priority in RUN is redirect (branch_req > jr_req > jump_req), then load_use, then HALT, then double, then normal.
- **Redirect:** pc_src is set to the winning source and kill=1. add_pc=1, stall=0, turn_off=0. State stays RUN. Redirect also aborts a pending double.
- **load_use:** stall=1, turn_off=1, kill=0. pc_src=0. State is unchanged.
- **HALT:** d_opcode==OP_HALT with no redirect and no load_use. Goes to HALT. kill=1, so the HALT word becomes a NOP.
- **Double issue:** d_opcode is OP_LDW or OP_SDW in RUN. add_pc=0 so the PC holds and the same word is fetched again. turn_off=1. Next state is DBL2.
  - If d_rd[0]==1: dbl_err pulses, the instruction is treated as single, and the state stays RUN.
- **DBL2:**
  - add_rd=1 and add_imm=1; add_pc=1; turn_off=0.
  - Returns to RUN next cycle.
  - A redirect in DBL2 wins and returns to RUN.
  - load_use in DBL2 holds DBL2, with stall=1 and add_rd/add_imm kept at 1.
  - The opcode is not re-decoded, so there is no triple issue.
- **HALT state:** stall=1, kill=1, turn_off=1 and halted=1 until clear. All requests are ignored.
- **Normal:** pc_src=0, add_pc=1, all other controls 0.
- **Counters:**
  - stall_cnt counts +1 per cycle with stall=1 while not halted.
  - kill_cnt counts +1 per redirect cycle.
  - dbl_cnt counts +1 per successful DBL2 exit.
  - Each counter saturates at all-ones.

## Timing
- pc_src, add_pc, stall, kill and turn_off are combinational (Mealy) from state and the current-cycle inputs. They take effect at the next rising clk.
- add_rd, add_imm and halted are decoded from the registered state only.
- dbl_err is combinational and lasts exactly one cycle.
- A double occupies exactly 2 fetch cycles, plus 1 per load_use cycle.
- A redirect costs 1 killed slot.
- **clear** (synchronous):
  - Next edge: state=RUN, all counters=0.
  - While clear=1, outputs are pc_src=0, add_pc=1, stall=0, kill=1 and turn_off=0; add_rd, add_imm, dbl_err and halted are 0.
  - clear mid-double or during HALT returns to RUN on that edge.
- **Simultaneous redirect and load_use:** the redirect wins and the stall is dropped, so the killed slot covers the hazard.

## Structure
- Shared package holds:
  - the pc_src encodings PC_SEQ=0, PC_BR=1, PC_JR=2, PC_J=3;
  - the state encodings RUN=2'd0, DBL2=2'd1, HALT=2'd2;
  - the opcode constants.
- One natural sub-module is `sat_counter` (WIDTH, en, clk, clear, out), instantiated three times.

## Test plan
- **Reset and sequential fetch:** clear=1 for 1 cycle, then an opcode stream of 5,7,5 with no requests → pc_src=0, add_pc=1 every cycle, all counters 0.
- **Double issue:** d_opcode=16, d_rd=4 → cycle 0: add_pc=0, turn_off=1; cycle 1: add_rd=add_imm=1, add_pc=1; cycle 2: RUN; dbl_cnt=1.
- **Odd-rd double:** d_opcode=17, d_rd=5 → dbl_err=1 for 1 cycle, add_pc=1, no DBL2, dbl_cnt unchanged.
- **Redirect priority:**
  - branch_req=1, jr_req=1, load_use=1 together → pc_src=1, kill=1, stall=0; kill_cnt=1.
  - jr_req with jump_req → pc_src=2.
- **Stall during DBL2:** enter DBL2, then load_use=1 for 2 cycles → state held in DBL2, stall=1, add_rd=1; exits after load_use drops; stall_cnt=2.
- **HALT then clear:** d_opcode=63 → halted=1 and stall=kill=1 persist over 10 cycles despite branch_req; clear → RUN, counters 0.
